// File: rtl/pwr_cfg_seq_if.sv
// Bus bundle between the configuration sequencer and its host/slave side.
// master: sequencer view (START/SPx_IN/MISO in; SSEL/SCK/MOSI/Rw/SCRx/BUSY/DONE/ERR/RDATA out).
interface pwr_cfg_seq_if;
    logic        START;
    logic [15:0] SP0_IN;
    logic [15:0] SP1_IN;
    logic [15:0] SP2_IN;
    logic        MISO;
    logic        SSEL;
    logic        SCK;
    logic        MOSI;
    logic        Rw;
    logic        SCR1;
    logic        SCR2;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [15:0] RDATA;

    modport master (
        input  START, SP0_IN, SP1_IN, SP2_IN, MISO,
        output SSEL, SCK, MOSI, Rw, SCR1, SCR2,
        output BUSY, DONE, ERR, RDATA
    );

    modport slave (
        output START, SP0_IN, SP1_IN, SP2_IN, MISO,
        input  SSEL, SCK, MOSI, Rw, SCR1, SCR2,
        input  BUSY, DONE, ERR, RDATA
    );
endinterface

// File: rtl/pwr_cfg_seq.sv
// Power-unit configuration sequencer: on START writes three setpoint words
// over a serial frame link (SSEL/SCK/MOSI, MSB first) with per-frame Rw/SCR1/SCR2.
// Ports: CLK, RSTn (async active-low), bus (pwr_cfg_seq_if.master).
// Params: CLK_DIV = SCK half-period in CLK cycles, GAP = SSEL-high cycles per frame.
// Macro PWR_CFG_READBACK_EN adds a fourth read frame; MISO -> RDATA, ERR on SP0 mismatch.
module pwr_cfg_seq #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input logic             CLK,
    input logic             RSTn,
    pwr_cfg_seq_if.master   bus
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_SHIFT, ST_GAP, ST_FIN
    } state_t;

    localparam logic [7:0] DIV_END = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_END = 8'(GAP - 1);
`ifdef PWR_CFG_READBACK_EN
    localparam logic [1:0] LAST = 2'd3;
`else
    localparam logic [1:0] LAST = 2'd2;
`endif

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [4:0]  bits, bits_n;
    logic        hi, hi_n;
    logic [1:0]  frame, frame_n;
    logic [15:0] sh, sh_n;
    logic [15:0] sp1, sp2;
    logic        load;
    logic        in_frame;
    logic        ssel_low;
    logic        rw, scr1, scr2;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            bits  <= '0;
            hi    <= 1'b0;
            frame <= '0;
            sh    <= '0;
            sp1   <= '0;
            sp2   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bits  <= bits_n;
            hi    <= hi_n;
            frame <= frame_n;
            sh    <= sh_n;
            if (load) begin
                sp1 <= bus.SP1_IN;
                sp2 <= bus.SP2_IN;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bits_n  = bits;
        hi_n    = hi;
        frame_n = frame;
        sh_n    = sh;
        load    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.START) begin
                    state_n = ST_SETUP;
                    cnt_n   = '0;
                    frame_n = '0;
                    sh_n    = bus.SP0_IN;
                    load    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt == DIV_END) begin
                    state_n = ST_SHIFT;
                    cnt_n   = '0;
                    hi_n    = 1'b1;
                    bits_n  = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (cnt != DIV_END) begin
                    cnt_n = cnt + 8'd1;
                end else begin
                    cnt_n = '0;
                    if (hi) begin
                        // falling SCK: present next bit, zero-fill
                        hi_n   = 1'b0;
                        sh_n   = {sh[14:0], 1'b0};
                        bits_n = bits + 5'd1;
                    end else if (bits == 5'd16) begin
                        state_n = ST_GAP;
                    end else begin
                        hi_n = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (cnt != GAP_END) begin
                    cnt_n = cnt + 8'd1;
                end else begin
                    cnt_n = '0;
                    if (frame == LAST) begin
                        state_n = ST_FIN;
                    end else begin
                        state_n = ST_SETUP;
                        frame_n = frame + 2'd1;
                        unique case (frame)
                            2'd0:    sh_n = sp1;
                            2'd1:    sh_n = sp2;
                            default: sh_n = '0;
                        endcase
                    end
                end
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Frame select lines come from the frame index, which only moves at the
    // end of GAP, so they stay put for the whole SETUP..GAP span.
    always_comb begin
        rw   = 1'b1;
        scr1 = 1'b0;
        scr2 = 1'b0;
        if (in_frame) begin
            unique case (frame)
                2'd0: rw = 1'b0;
                2'd1: begin
                    rw   = 1'b0;
                    scr1 = 1'b1;
                    scr2 = 1'b1;
                end
                2'd2: begin
                    rw   = 1'b0;
                    scr1 = 1'b1;
                end
                default: rw = 1'b1;
            endcase
        end
    end

    assign ssel_low = (state == ST_SETUP) || (state == ST_SHIFT);
    assign in_frame = ssel_low || (state == ST_GAP);

    assign bus.SSEL = !ssel_low;
    assign bus.SCK  = (state == ST_SHIFT) && hi;
    assign bus.MOSI = ssel_low && sh[15];
    assign bus.Rw   = rw;
    assign bus.SCR1 = scr1;
    assign bus.SCR2 = scr2;
    assign bus.BUSY = in_frame;
    assign bus.DONE = (state == ST_FIN);

`ifdef PWR_CFG_READBACK_EN
    logic [15:0] sp0, rx, rdata;
    logic        err;
    logic        sck_rise, ssel_rise;

    // MISO is taken on the same edge that raises SCK.
    assign sck_rise =
        ((state == ST_SETUP) && (cnt == DIV_END)) ||
        ((state == ST_SHIFT) && !hi && (cnt == DIV_END) &&
         (bits != 5'd16));
    assign ssel_rise =
        (state == ST_SHIFT) && !hi && (cnt == DIV_END) &&
        (bits == 5'd16);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sp0   <= '0;
            rx    <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            if (load) begin
                sp0 <= bus.SP0_IN;
                err <= 1'b0;
            end
            if (sck_rise) begin
                rx <= {rx[14:0], bus.MISO};
            end
            if (ssel_rise && (frame == LAST)) begin
                rdata <= rx;
                err   <= (rx != sp0);
            end
        end
    end

    assign bus.ERR   = err;
    assign bus.RDATA = rdata;
`else
    logic unused_miso;

    assign unused_miso = bus.MISO;
    assign bus.ERR     = 1'b0;
    assign bus.RDATA   = '0;
`endif

endmodule

// File: tb/tb_pwr_cfg_seq.sv
// Self-checking bench for pwr_cfg_seq: default instance plus a CLK_DIV=2/GAP=4
// instance, slave-side frame decoder feeding a scoreboard of expected frames.
module tb_pwr_cfg_seq;

`ifdef PWR_CFG_READBACK_EN
    localparam int NFR = 4;
    localparam bit RB  = 1'b1;
`else
    localparam int NFR = 3;
    localparam bit RB  = 1'b0;
`endif

    typedef struct {
        int          id;
        logic        rw;
        logic        s1;
        logic        s2;
        logic [15:0] word;
    } frame_t;

    typedef struct {
        logic [15:0] sp0;
        logic [15:0] sp1;
        logic [15:0] sp2;
        logic [15:0] ret;
        logic        e_err;
        logic [15:0] e_rdata;
    } vec_t;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    frame_t exp_q[$];

    logic        prev_ssel[2];
    logic        prev_sck[2];
    int          rises[2];
    int          low[2];
    int          idle_sck[2];
    int          tail_bad[2];
    int          ctrl_bad[2];
    int          fdone[2];
    logic [15:0] sh[2];
    logic [15:0] ret_word[2];
    logic [2:0]  ctrl[2];
    int          div_of[2];
    logic        m0, m1;

    always #5 CLK = ~CLK;

    pwr_cfg_seq_if b0();
    pwr_cfg_seq_if b1();

    pwr_cfg_seq u0 (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (b0)
    );

    pwr_cfg_seq #(.CLK_DIV(2), .GAP(4)) u1 (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (b1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic g_busy(input int id);
        return (id == 0) ? b0.BUSY : b1.BUSY;
    endfunction

    function automatic logic g_done(input int id);
        return (id == 0) ? b0.DONE : b1.DONE;
    endfunction

    function automatic logic g_ssel(input int id);
        return (id == 0) ? b0.SSEL : b1.SSEL;
    endfunction

    function automatic logic g_err(input int id);
        return (id == 0) ? b0.ERR : b1.ERR;
    endfunction

    function automatic logic [15:0] g_rdata(input int id);
        return (id == 0) ? b0.RDATA : b1.RDATA;
    endfunction

    task automatic drive(input int id, input logic s,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c);
        if (id == 0) begin
            b0.START  = s;
            b0.SP0_IN = a;
            b0.SP1_IN = b;
            b0.SP2_IN = c;
        end else begin
            b1.START  = s;
            b1.SP0_IN = a;
            b1.SP1_IN = b;
            b1.SP2_IN = c;
        end
    endtask

    // Slave-side decoder, evaluated on the falling CLK edge.
    task automatic mon(input int id, input logic ssel, input logic sck,
                       input logic mosi, input logic rw, input logic s1,
                       input logic s2, output logic miso);
        frame_t e;
        if (!RSTn) begin
            prev_ssel[id] = 1'b1;
            prev_sck[id]  = 1'b0;
            rises[id]     = 0;
            low[id]       = 0;
            idle_sck[id]  = 0;
            tail_bad[id]  = 0;
            ctrl_bad[id]  = 0;
            miso          = 1'b0;
            return;
        end
        if (ssel) begin
            if (sck) idle_sck[id]++;
            if (!prev_ssel[id]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(id + 1), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_id", 32'(id), 32'(e.id));
                    chk("mosi_word", 32'(sh[id]), 32'(e.word));
                    chk("ctrl_end", 32'({rw, s1, s2}),
                        32'({e.rw, e.s1, e.s2}));
                end
                chk("ctrl_stable", 32'(ctrl_bad[id]), 32'd0);
                chk("sck_rises", 32'(rises[id]), 32'd16);
                chk("ssel_low", 32'(low[id]), 32'(33 * div_of[id]));
                chk("mosi_tail", 32'(tail_bad[id]), 32'd0);
                fdone[id]++;
            end
        end else begin
            if (prev_ssel[id]) begin
                chk("idle_sck", 32'(idle_sck[id]), 32'd0);
                idle_sck[id] = 0;
                rises[id]    = 0;
                low[id]      = 0;
                tail_bad[id] = 0;
                ctrl_bad[id] = 0;
                ctrl[id]     = {rw, s1, s2};
            end
            low[id]++;
            if (sck && !prev_sck[id]) begin
                sh[id] = {sh[id][14:0], mosi};
                rises[id]++;
            end
            if ({rw, s1, s2} != ctrl[id]) ctrl_bad[id]++;
            if (rises[id] == 16 && !sck && mosi) tail_bad[id]++;
        end
        prev_ssel[id] = ssel;
        prev_sck[id]  = sck;
        if (!ssel && rises[id] < 16) miso = ret_word[id][15 - rises[id]];
        else miso = 1'b0;
    endtask

    always @(negedge CLK) begin
        mon(0, b0.SSEL, b0.SCK, b0.MOSI, b0.Rw, b0.SCR1, b0.SCR2, m0);
        b0.MISO = m0;
        mon(1, b1.SSEL, b1.SCK, b1.MOSI, b1.Rw, b1.SCR1, b1.SCR2, m1);
        b1.MISO = m1;
    end

    task automatic push_seq(input int id, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] c);
        exp_q.push_back('{id, 1'b0, 1'b0, 1'b0, a});
        exp_q.push_back('{id, 1'b0, 1'b1, 1'b1, b});
        exp_q.push_back('{id, 1'b0, 1'b1, 1'b0, c});
        if (RB) exp_q.push_back('{id, 1'b1, 1'b0, 1'b0, 16'h0000});
    endtask

    // Pulse START from the falling edge; returns in the first SETUP cycle.
    task automatic start_seq(input int id, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] c);
        @(negedge CLK);
        fdone[id] = 0;
        drive(id, 1'b1, a, b, c);
        push_seq(id, a, b, c);
        @(negedge CLK);
        drive(id, 1'b0, ~a, ~b, ~c);
        chk("start_busy", 32'(g_busy(id)), 32'd1);
        chk("start_ssel", 32'(g_ssel(id)), 32'd0);
        chk("start_err_clr", 32'(g_err(id)), 32'd0);
    endtask

    // Runs to the FIN cycle; optional ignored START pulse at cycle mid.
    task automatic finish_seq(input int id, input int mid,
                              input logic e_err, input logic [15:0] e_rd);
        int n;
        int lim;
        logic busy_ok;
        lim = (id == 0) ? NFR * 140 : NFR * 70;
        n = 0;
        busy_ok = 1'b1;
        while (!g_done(id) && n <= lim + 10) begin
            if (!g_busy(id)) busy_ok = 1'b0;
            if (n == mid) drive(id, 1'b1, 16'h0F0F, 16'hF0F0, 16'h3C3C);
            else if (n == mid + 1) drive(id, 1'b0, 16'h0, 16'h0, 16'h0);
            @(negedge CLK);
            n++;
        end
        chk("busy_hold", 32'(busy_ok), 32'd1);
        chk("seq_len", 32'(n), 32'(lim));
        chk("fin_busy", 32'(g_busy(id)), 32'd0);
        chk("fin_err", 32'(g_err(id)), 32'(e_err));
        chk("fin_rdata", 32'(g_rdata(id)), 32'(e_rd));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec[4];
        int k;
        vec[0] = '{16'h8231, 16'h1234, 16'hFFFF, 16'h8231,
                   1'b0, RB ? 16'h8231 : 16'h0};
        vec[1] = '{16'h8231, 16'h0000, 16'h5A5A, 16'h8230,
                   RB, RB ? 16'h8230 : 16'h0};
        vec[2] = '{16'h0001, 16'h8000, 16'hA5C3, 16'h0001,
                   1'b0, RB ? 16'h0001 : 16'h0};
        vec[3] = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h1234,
                   RB, RB ? 16'h1234 : 16'h0};
        div_of[0] = 4;
        div_of[1] = 2;
        drive(0, 1'b0, 16'h0, 16'h0, 16'h0);
        drive(1, 1'b0, 16'h0, 16'h0, 16'h0);
        ret_word[0] = 16'h0;
        ret_word[1] = 16'h0;
        repeat (3) @(negedge CLK);
        chk("rst_ssel", 32'(b0.SSEL), 32'd1);
        chk("rst_sck", 32'(b0.SCK), 32'd0);
        chk("rst_mosi", 32'(b0.MOSI), 32'd0);
        chk("rst_rw", 32'(b0.Rw), 32'd1);
        chk("rst_scr", 32'({b0.SCR1, b0.SCR2}), 32'd0);
        chk("rst_busy_done", 32'({b0.BUSY, b0.DONE}), 32'd0);
        chk("rst_err", 32'(b0.ERR), 32'd0);
        chk("rst_rdata", 32'(b0.RDATA), 32'd0);
        RSTn = 1'b1;

        for (int i = 0; i < 4; i++) begin
            ret_word[0] = vec[i].ret;
            start_seq(0, vec[i].sp0, vec[i].sp1, vec[i].sp2);
            finish_seq(0, -1, vec[i].e_err, vec[i].e_rdata);
            @(negedge CLK);
            chk("done_pulse", 32'(b0.DONE), 32'd0);
        end

        // START mid-sequence and in FIN ignored; first IDLE cycle accepted
        ret_word[0] = 16'h8231;
        start_seq(0, 16'h8231, 16'h1234, 16'hFFFF);
        finish_seq(0, 100, 1'b0, RB ? 16'h8231 : 16'h0);
        drive(0, 1'b1, 16'h1111, 16'h2222, 16'h3333);
        @(negedge CLK);
        drive(0, 1'b0, 16'h0, 16'h0, 16'h0);
        chk("fin_start_ign", 32'(b0.BUSY), 32'd0);
        chk("fin_one_cycle", 32'(b0.DONE), 32'd0);
        ret_word[0] = 16'h1111;
        drive(0, 1'b1, 16'h1111, 16'h2222, 16'h3333);
        push_seq(0, 16'h1111, 16'h2222, 16'h3333);
        fdone[0] = 0;
        @(negedge CLK);
        drive(0, 1'b0, 16'h0, 16'h0, 16'h0);
        chk("post_fin_start", 32'(b0.BUSY), 32'd1);
        finish_seq(0, -1, 1'b0, RB ? 16'h1111 : 16'h0);
        chk("sb_empty_a", 32'(exp_q.size()), 32'd0);

        // reset at the 5th SCK pulse of the SP1 frame
        ret_word[0] = 16'hC0DE;
        start_seq(0, 16'hC0DE, 16'hBEEF, 16'h0F0F);
        k = 0;
        while (!(fdone[0] == 1 && rises[0] == 5 && b0.SCK) && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        chk("reach_pulse5", 32'(k < 2000), 32'd1);
        #2 RSTn = 1'b0;
        #1;
        chk("arst_ssel", 32'(b0.SSEL), 32'd1);
        chk("arst_sck", 32'(b0.SCK), 32'd0);
        chk("arst_busy", 32'(b0.BUSY), 32'd0);
        chk("arst_rw", 32'(b0.Rw), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        start_seq(0, 16'hC0DE, 16'hBEEF, 16'h0F0F);
        finish_seq(0, -1, 1'b0, RB ? 16'hC0DE : 16'h0);
        chk("rerun_frames", 32'(fdone[0]), 32'(NFR));

        // fast instance: CLK_DIV=2, GAP=4
        ret_word[1] = 16'h4321;
        start_seq(1, 16'h1357, 16'h2468, 16'h9ACE);
        finish_seq(1, -1, RB, RB ? 16'h4321 : 16'h0);
        chk("fast_frames", 32'(fdone[1]), 32'(NFR));

        repeat (4) @(negedge CLK);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwr_cfg_seq.md
PWR_CFG_SEQ -- requirements
Module: pwr_cfg_seq

Interface
REQ-001 Parameter CLK_DIV, default 4: SCK half-period in CLK cycles; legal range 2..255.
REQ-002 Parameter GAP, default 8: CLK cycles SSEL is held high after each frame; legal range 4..255.
REQ-003 CLK  in  1  single system clock; all logic on its rising edge.
REQ-004 RSTn  in  1  reset, asynchronous, active-low.
REQ-005 START  in  1  one-cycle request to run one configuration sequence.
REQ-006 SP0_IN, SP1_IN, SP2_IN  in  16 each  setpoint words to load into the power unit.
REQ-007 MISO  in  1  serial data from the power unit.
REQ-008 SSEL  out  1  frame select to the power unit; active-low.
REQ-009 SCK  out  1  serial clock; idles low.
REQ-010 MOSI  out  1  serial data, MSB first.
REQ-011 Rw  out  1  0 = write frame, 1 = read frame.
REQ-012 SCR1, SCR2  out  1 each  target setpoint select.
REQ-013 BUSY  out  1  sequence in progress.
REQ-014 DONE  out  1  one-cycle pulse at sequence end.
REQ-015 ERR  out  1  readback mismatch flag.
REQ-016 RDATA  out  16  last readback word.

Function
REQ-017 States SHALL be IDLE, SETUP, SHIFT, GAP, FIN; FIN lasts 1 cycle and returns to IDLE.
REQ-018 START in IDLE SHALL latch SP0_IN..SP2_IN, clear ERR, and enter SETUP next cycle with BUSY=1 and SSEL=0.
REQ-019 START outside IDLE SHALL be ignored; START in the FIN cycle SHALL be ignored; START in the first IDLE cycle after FIN SHALL be accepted.
REQ-020 Frame order SHALL be: SP0 (SCR1=0, SCR2=0), SP1 (SCR1=1, SCR2=1), SP2 (SCR1=1, SCR2=0); Rw=0 for all three.
REQ-021 SETUP SHALL last CLK_DIV cycles with SCK=0, MOSI = bit 15 of the current word, and Rw/SCR1/SCR2 valid.
REQ-022 SHIFT SHALL issue exactly 16 SCK pulses, each CLK_DIV cycles high then CLK_DIV cycles low.
REQ-023 MOSI SHALL advance to the next lower bit on the cycle SCK falls; after the 16th fall MOSI SHALL be 0.
REQ-024 SSEL SHALL rise on the cycle after the 16th low phase completes, so the slave bit counter reaches 16.
REQ-025 SSEL low time SHALL be 33*CLK_DIV cycles per frame.
REQ-026 GAP SHALL hold SSEL=1 for GAP cycles, then start the next frame in SETUP or go to FIN.
REQ-027 Rw/SCR1/SCR2 SHALL stay constant from SETUP entry to the end of GAP, so the slave commits to the correct register.
REQ-028 DONE SHALL be high only in FIN; BUSY SHALL be 0 in FIN.
REQ-029 Sequence length with defaults: 3 x (132 + 8) = 420 cycles from the first SETUP cycle to FIN.
REQ-030 SCK SHALL never toggle while SSEL=1.

Reset
REQ-031 On RSTn=0, outputs SHALL immediately become: SSEL=1, SCK=0, MOSI=0, Rw=1, SCR1=0, SCR2=0, BUSY=0, DONE=0, ERR=0, RDATA=0; state SHALL become IDLE.
REQ-032 A reset mid-frame SHALL abort with no resume; the slave may have captured a partial word, and the host SHALL rerun the sequence.

Configuration
REQ-033 Macro PWR_CFG_READBACK_EN defined: after the SP2 frame, run a fourth frame with Rw=1, SCR1=0, SCR2=0, MOSI=0.
REQ-034 In the readback frame, MISO SHALL be sampled on the CLK edge that drives each SCK rise, shifted in MSB first, and loaded into RDATA at SSEL rise.
REQ-035 At SSEL rise of the readback frame, ERR SHALL be set if RDATA differs from latched SP0; ERR holds until the next accepted START or reset.
REQ-036 Macro PWR_CFG_READBACK_EN undefined: no fourth frame, ERR tied 0, RDATA tied 0, sequence 420 cycles with defaults.

Verification
REQ-037 Defaults, START with SP0=16'h8231, SP1=16'h1234, SP2=16'hFFFF -> three frames with correct SCR1/SCR2; decoded MOSI words match; DONE at cycle 420; BUSY high throughout.
REQ-038 Slave model returning MISO=16'h8231, READBACK_EN defined -> RDATA=16'h8231, ERR=0, DONE at cycle 560.
REQ-039 Slave model returning 16'h8230 -> ERR=1 at readback SSEL rise; next START clears ERR.
REQ-040 START pulsed mid-sequence and in the FIN cycle -> ignored, frame count stays 3 (4 with readback); START the cycle after FIN -> new sequence begins.
REQ-041 RSTn low at the 5th SCK pulse of the SP1 frame -> SSEL=1 and SCK=0 asynchronously, BUSY=0; new START runs a full 3-frame sequence.
REQ-042 CLK_DIV=2, GAP=4 -> SSEL low 66 cycles per frame, exactly 16 SCK rises per frame, no SCK activity while SSEL=1.
